sram_like_arbiter: RTL and testbench
====================================

// Module: sram_like_arbiter
// PURPOSE
//  Memory-side arbiter below the CPU core. It merges the core's instruction-fetch and data
//  SRAM-like ports (req/addr_ok/data_ok handshake) onto one single-port memory bus with
//  variable latency. At most one transaction is outstanding on the memory bus at any time.
//  Data has fixed priority over instruction, with an anti-starvation counter that bounds how
//  long instruction fetch can be held off.
// PARAMETERS
//  STARVE_MAX  4  consecutive data grants, while inst_req is pending, before inst is forced ahead
// PORTS
//  clk            in   1   clock; all logic samples on the rising edge
//  reset          in   1   asynchronous, active-high reset
//  inst_req       in   1   instruction master request
//  inst_wr        in   1   1 = write, 0 = read
//  inst_wstrb     in   4   byte strobes, used only when inst_wr=1
//  inst_addr      in   32  byte address
//  inst_wdata     in   32  write data
//  inst_addr_ok   out  1   request accepted this cycle
//  inst_data_ok   out  1   one-cycle response pulse
//  inst_rdata     out  32  read data; valid while inst_data_ok=1, held until the next inst response
//  data_req/data_wr/data_wstrb/data_addr/data_wdata  in   same widths as inst_*; data master request
//  data_addr_ok/data_data_ok/data_rdata             out  same widths as inst_*; data master response
//  mem_req        out  1   memory request
//  mem_we         out  4   byte write enables; 0 = read
//  mem_addr       out  32  memory address
//  mem_wdata      out  32  memory write data
//  mem_gnt        in   1   memory accepts mem_req this cycle
//  mem_rvalid     in   1   response for the outstanding transaction (both reads and writes)
//  mem_rdata      in   32  read data, valid with mem_rvalid
// BEHAVIOUR
//  - FSM states: IDLE, BUSY. Register owner: 0 = inst, 1 = data.
//  - IDLE:
//    * mem_req = inst_req | data_req.
//    * sel = data if data_req & !(inst_req & starve_cnt==STARVE_MAX), else inst.
//    * mem_addr, mem_wdata and mem_we = (wr ? wstrb : 4'b0) come combinationally from sel.
//    * <sel>_addr_ok = mem_gnt & mem_req. The other master's addr_ok = 0.
//  - IDLE with mem_req & mem_gnt: next state BUSY; owner <= sel.
//  - BUSY:
//    * mem_req = 0, both addr_ok = 0, mem_we = 0.
//    * mem_rvalid: next state IDLE; latch mem_rdata into the owner's rdata register.
//    * Next cycle, owner's data_ok = 1 for exactly one cycle.
//  - Latency: grant at cycle T, mem_rvalid at T+k (k>=1), data_ok at T+k+1.
//    Earliest next grant is T+k+1, which may coincide with that data_ok pulse.
//  - mem_rvalid while IDLE is ignored: no state change, no data_ok.
//  - mem_gnt=0 with mem_req=1: stay IDLE, no addr_ok. Masters hold their request stable.
//    sel is re-evaluated every cycle.
//  - starve_cnt (width clog2(STARVE_MAX+1)), updated only on a grant:
//    * data grant while inst_req=1: +1, saturating at STARVE_MAX.
//    * inst grant, or data grant while inst_req=0: cleared.
//  - rdata registers are updated only on their own master's response. Write responses also
//    latch mem_rdata; that value is don't-care.
//  - Reset (async, any state):
//    * state=IDLE, owner=0, starve_cnt=0.
//    * inst_data_ok = data_data_ok = 0; inst_rdata = data_rdata = 0.
//    * An outstanding transaction is dropped; a later mem_rvalid is ignored per the IDLE rule.
//  - Combinational outputs (mem_*, *_addr_ok) are 0 when no request is present.
// TESTING
//  1. data read 0x1C000100, gnt=1 @T, rvalid @T+2 with 0xDEADBEEF
//     -> data_addr_ok @T; data_data_ok @T+3; data_rdata=0xDEADBEEF; all inst_* outputs 0.
//  2. inst_req and data_req both high @T, gnt=1
//     -> data granted @T; inst_addr_ok 0 until data_data_ok; inst granted on the cycle of data_data_ok.
//  3. data_req and inst_req held high, k=1, STARVE_MAX=4
//     -> grants are D,D,D,D,I,D...; starve_cnt returns to 0 after the inst grant.
//  4. data write, wstrb=4'b0011, addr 0x8
//     -> mem_we=4'b0011 and mem_wdata passed through @grant; data_data_ok pulses one cycle
//        after mem_rvalid; data_rdata is unchanged.
//  5. mem_gnt=0 for 3 cycles under inst read 0x1C000000
//     -> mem_req=1 and mem_addr stable, inst_addr_ok=0 for 3 cycles; grant on the 4th cycle.
//  6. reset pulsed while BUSY, then mem_rvalid=1
//     -> IDLE after reset, no data_ok pulse, rdata=0, a new request is granted normally.

Source files
------------

// File: rtl/sram_like_arbiter.sv
// Merges the core's instruction and data SRAM-like ports onto one single-outstanding memory bus.
// Data wins by default; a starvation counter forces instruction fetch ahead after STARVE_MAX data grants.
//
// state | meaning
// IDLE  | no transaction outstanding; requests may be granted
// BUSY  | one transaction outstanding, waiting for mem_rvalid
module sram_like_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_nxt;
  logic            owner;
  logic [CW-1:0]   starve_cnt;
  logic            sel_data;
  logic            grant;
  logic            resp;

  // Instruction is forced ahead only when it is waiting and data has had its full run.
  assign sel_data = data_req & ~(inst_req & (starve_cnt == CW'(STARVE_MAX)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    mem_req      = 1'b0;
    mem_we       = 4'b0;
    mem_addr     = 32'b0;
    mem_wdata    = 32'b0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    grant        = 1'b0;
    resp         = 1'b0;
    case (state)
      IDLE: begin
        mem_req = inst_req | data_req;
        if (mem_req) begin
          mem_addr  = sel_data ? data_addr  : inst_addr;
          mem_wdata = sel_data ? data_wdata : inst_wdata;
          mem_we    = sel_data ? (data_wr ? data_wstrb : 4'b0)
                               : (inst_wr ? inst_wstrb : 4'b0);
        end
        if (mem_req & mem_gnt) begin
          grant        = 1'b1;
          inst_addr_ok = ~sel_data;
          data_addr_ok = sel_data;
          state_nxt    = BUSY;
        end
      end
      BUSY: begin
        if (mem_rvalid) begin
          resp      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner      <= 1'b0;
      starve_cnt <= '0;
    end else if (grant) begin
      owner <= sel_data;
      if (sel_data & inst_req) begin
        if (starve_cnt != CW'(STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
      inst_rdata   <= 32'b0;
      data_rdata   <= 32'b0;
    end else begin
      inst_data_ok <= resp & ~owner;
      data_data_ok <= resp & owner;
      if (resp & ~owner) inst_rdata <= mem_rdata;
      if (resp & owner)  data_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Randomized bench for sram_like_arbiter: bench-side masters and memory, checked every cycle
// against a transaction-level model of the arbitration rules.
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_gnt, mem_rvalid;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  sram_like_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_wstrb(inst_wstrb), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Masters: index 0 = inst, 1 = data.
  bit          act[2];
  bit          mwr[2];
  logic [3:0]  mstrb[2];
  logic [31:0] maddr[2];
  logic [31:0] mwdata[2];

  // Reference model state.
  bit          m_busy;
  bit          m_iok, m_dok;
  int          m_starve;
  logic [31:0] m_irdata, m_drdata;
  int          lat_left;
  bit          pend_owner, pend_wr;

  bit          exp_req, sel_d, s, gnt, rv;
  logic [31:0] rd;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_we;
  int          issue_pct, gnt_pct;

  task automatic model_reset();
    m_busy   = 1'b0;
    m_iok    = 1'b0;
    m_dok    = 1'b0;
    m_starve = 0;
    m_irdata = 32'b0;
    m_drdata = 32'b0;
  endtask

  task automatic check_outputs(input string ph);
    chk({ph, " inst_data_ok"}, inst_data_ok, m_iok);
    chk({ph, " data_data_ok"}, data_data_ok, m_dok);
    chk({ph, " inst_rdata"}, inst_rdata, m_irdata);
    chk({ph, " data_rdata"}, data_rdata, m_drdata);
    chk({ph, " mem_req"}, mem_req, exp_req);
    chk({ph, " mem_we"}, mem_we, exp_we);
    chk({ph, " inst_addr_ok"}, inst_addr_ok, exp_req && gnt && !sel_d);
    chk({ph, " data_addr_ok"}, data_addr_ok, exp_req && gnt && sel_d);
    if (!m_busy) begin
      chk({ph, " mem_addr"}, mem_addr, exp_addr);
      chk({ph, " mem_wdata"}, mem_wdata, exp_wdata);
    end
  endtask

  initial begin
    reset = 1'b1;
    inst_req = 0; inst_wr = 0; inst_wstrb = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    for (int m = 0; m < 2; m++) act[m] = 1'b0;
    model_reset();
    lat_left = 0;
    pend_owner = 1'b0;
    pend_wr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    exp_req = 1'b0; sel_d = 1'b0; gnt = 1'b0; exp_we = 4'b0; exp_addr = 0; exp_wdata = 0;
    check_outputs("reset");

    for (int cyc = 0; cyc < 3000; cyc++) begin
      issue_pct = (cyc < 400) ? 100 : 60;
      gnt_pct   = (cyc < 400) ? 100 : 70;
      @(negedge clk);
      if (m_busy && $urandom_range(59) == 0) begin
        reset = 1'b1;
        #1;
        reset = 1'b0;
        model_reset();
      end
      for (int m = 0; m < 2; m++) begin
        if (!act[m] && $urandom_range(99) < issue_pct) begin
          act[m]    = 1'b1;
          mwr[m]    = $urandom_range(3) == 0;
          mstrb[m]  = 4'($urandom);
          maddr[m]  = $urandom;
          mwdata[m] = $urandom;
        end
      end
      inst_req = act[0]; inst_wr = mwr[0]; inst_wstrb = mstrb[0];
      inst_addr = maddr[0]; inst_wdata = mwdata[0];
      data_req = act[1]; data_wr = mwr[1]; data_wstrb = mstrb[1];
      data_addr = maddr[1]; data_wdata = mwdata[1];

      // Memory: respond when the chosen latency expires; write responses return the
      // owner's current read value so a write leaves its rdata unchanged.
      rv = 1'b0;
      rd = $urandom;
      if (lat_left == 1) begin
        rv = 1'b1;
        if (pend_wr && m_busy) rd = pend_owner ? m_drdata : m_irdata;
      end else if (lat_left == 0 && !m_busy && $urandom_range(9) == 0) begin
        rv = 1'b1;
      end
      gnt = (lat_left == 0) && ($urandom_range(99) < gnt_pct);
      mem_rvalid = rv;
      mem_rdata  = rd;
      mem_gnt    = gnt;

      exp_req   = !m_busy && (act[0] || act[1]);
      sel_d     = act[1] && !(act[0] && m_starve == 4);
      s         = sel_d;
      exp_addr  = exp_req ? maddr[s]  : 32'b0;
      exp_wdata = exp_req ? mwdata[s] : 32'b0;
      exp_we    = (exp_req && mwr[s]) ? mstrb[s] : 4'b0;
      #1;
      check_outputs("run");

      // Advance the model across the coming rising edge.
      m_iok = 1'b0;
      m_dok = 1'b0;
      if (lat_left > 0) lat_left--;
      if (m_busy) begin
        if (rv) begin
          m_busy = 1'b0;
          if (pend_owner) begin m_dok = 1'b1; m_drdata = rd; end
          else            begin m_iok = 1'b1; m_irdata = rd; end
        end
      end else if (exp_req && gnt) begin
        m_busy     = 1'b1;
        pend_owner = s;
        pend_wr    = mwr[s];
        if (s && act[0]) m_starve = (m_starve >= 4) ? 4 : m_starve + 1;
        else             m_starve = 0;
        act[s]   = 1'b0;
        lat_left = $urandom_range(4, 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
